// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 LCD sequencer.
// Contents: HD44780 command bytes, the power-up init sequence, frame size,
// FSM state encodings shared by lcd_sequenciador and lcd_byte_writer, and a
// small max helper used to size the phase counter.
package lcd_pkg;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;
    localparam logic [7:0] CMD_FUNC  = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CMD_DISP  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] CMD_ENTRY = 8'h06;  // increment, no shift

    localparam int unsigned INIT_BYTES  = 4;
    localparam int unsigned FRAME_BYTES = 18;

    localparam logic [7:0] INIT_SEQ [INIT_BYTES] = '{CMD_FUNC, CMD_DISP, CMD_ENTRY, CMD_CLEAR};

    typedef logic [3:0] state_t;

    // Sequencer-level states
    localparam state_t ST_PWR_WAIT = 4'd0;
    localparam state_t ST_INIT     = 4'd1;
    localparam state_t ST_IDLE     = 4'd2;
    localparam state_t ST_FRAME    = 4'd3;
    localparam state_t ST_DONE     = 4'd4;
    // Byte-writer phases (the writer also uses ST_IDLE)
    localparam state_t ST_LOAD     = 4'd5;
    localparam state_t ST_SETUP    = 4'd6;
    localparam state_t ST_PULSE    = 4'd7;
    localparam state_t ST_HOLD     = 4'd8;
    localparam state_t ST_WAIT     = 4'd9;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_sequenciador_if.sv
// Frame handshake between the instruction text encoder (master) and the LCD
// sequencer (slave).
//   start   : one-cycle request to send a frame
//   palavra : 18 frame bytes, byte i at [8i+7:8i]
//   RS_list : RS per byte, 1 = data, 0 = command
//   busy    : sequencer not idle
//   done    : one-cycle pulse at frame completion
interface lcd_sequenciador_if;

    logic                                   start;
    logic [8*lcd_pkg::FRAME_BYTES-1:0]      palavra;
    logic [lcd_pkg::FRAME_BYTES-1:0]        RS_list;
    logic                                   busy;
    logic                                   done;

    modport master (output start, output palavra, output RS_list, input busy, input done);
    modport slave  (input start, input palavra, input RS_list, output busy, output done);

endinterface

// File: rtl/lcd_byte_writer.sv
// Writes one byte to an HD44780 in 8-bit mode with LOAD/SETUP/PULSE/HOLD/WAIT
// timing, using a single shared down-counter for every phase.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   go         : accept data/rs (honoured when idle or on the last WAIT cycle)
//   data, rs   : byte and register select to write
//   ready      : one-cycle pulse on the last WAIT cycle of a byte
//   lcd_data, lcd_rs, lcd_en : LCD pins
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES = 2,
    parameter int unsigned EN_CYCLES    = 25,
    parameter int unsigned HOLD_CYCLES  = 2,
    parameter int unsigned SHORT_WAIT   = 2500,
    parameter int unsigned LONG_WAIT    = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    input  logic [7:0] data,
    input  logic       rs,
    output logic       ready,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_en
);

    localparam int unsigned MAX_CYCLES = max2(max2(max2(SETUP_CYCLES, EN_CYCLES),
                                                   max2(HOLD_CYCLES, SHORT_WAIT)), LONG_WAIT);
    localparam int unsigned CW = $clog2(MAX_CYCLES) + 1;

    typedef logic [CW-1:0] cnt_t;

    state_t     state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic [7:0] data_q;
    logic       rs_q;
    logic       load;
    logic       long_wait;

    // Clear and home need the long execution time; only as commands
    assign long_wait = !rs_q && (data_q == CMD_CLEAR || data_q == CMD_HOME);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready   = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            ST_IDLE: load = go;
            ST_LOAD: begin
                state_d = ST_SETUP;
                cnt_d   = cnt_t'(SETUP_CYCLES - 1);
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_PULSE;
                    cnt_d   = cnt_t'(EN_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = cnt_t'(HOLD_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_WAIT;
                    cnt_d   = long_wait ? cnt_t'(LONG_WAIT - 1) : cnt_t'(SHORT_WAIT - 1);
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    ready   = 1'b1;
                    state_d = ST_IDLE;
                    // Chaining here keeps consecutive bytes gap-free
                    load    = go;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                data_q <= data;
                rs_q   <= rs;
            end
        end
    end

    assign lcd_data = data_q;
    assign lcd_rs   = rs_q;
    assign lcd_en   = (state_q == ST_PULSE);

endmodule

// File: rtl/lcd_sequenciador.sv
// HD44780 8-bit write-only sequencer: power-up delay, init bytes, then
// 18-byte frames latched on start and streamed byte 0 first.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : frame handshake (start/palavra/RS_list in, busy/done out)
//   lcd_data, lcd_rs, lcd_rw, lcd_en : LCD pins (lcd_rw tied low)
module lcd_sequenciador
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES = 2,
    parameter int unsigned EN_CYCLES    = 25,
    parameter int unsigned HOLD_CYCLES  = 2,
    parameter int unsigned SHORT_WAIT   = 2500,
    parameter int unsigned LONG_WAIT    = 100000,
    parameter int unsigned POWERUP_WAIT = 1000000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    lcd_sequenciador_if.slave         bus,
    output logic [7:0]                lcd_data,
    output logic                      lcd_rs,
    output logic                      lcd_rw,
    output logic                      lcd_en
);

    localparam int unsigned PW = $clog2(POWERUP_WAIT) + 1;
    localparam int unsigned IW = $clog2(FRAME_BYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_BYTES - 1);

    state_t                 state_q, state_d;
    logic [PW-1:0]          pwr_cnt_q, pwr_cnt_d;
    logic [1:0]             init_idx_q, init_idx_d, init_next;
    logic [IW-1:0]          idx_q, idx_d, idx_next;
    logic [7:0]             frame_q [FRAME_BYTES];
    logic [FRAME_BYTES-1:0] rs_list_q;
    logic                   latch;
    logic                   go;
    logic [7:0]             go_data;
    logic                   go_rs;
    logic                   ready;

    assign init_next = init_idx_q + 2'd1;
    assign idx_next  = idx_q + IW'(1);

    always_comb begin
        state_d    = state_q;
        pwr_cnt_d  = pwr_cnt_q;
        init_idx_d = init_idx_q;
        idx_d      = idx_q;
        latch      = 1'b0;
        go         = 1'b0;
        go_data    = 8'h00;
        go_rs      = 1'b0;
        unique case (state_q)
            ST_PWR_WAIT: begin
                if (pwr_cnt_q == PW'(POWERUP_WAIT - 1)) begin
                    go         = 1'b1;
                    go_data    = INIT_SEQ[0];
                    init_idx_d = 2'd0;
                    state_d    = ST_INIT;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + PW'(1);
                end
            end
            ST_INIT: begin
                if (ready) begin
                    if (init_idx_q == 2'(INIT_BYTES - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        go         = 1'b1;
                        go_data    = INIT_SEQ[init_next];
                        init_idx_d = init_next;
                    end
                end
            end
            ST_IDLE: begin
                if (bus.start) begin
                    // Byte 0 comes straight from the inputs so LOAD follows start
                    latch   = 1'b1;
                    go      = 1'b1;
                    go_data = bus.palavra[7:0];
                    go_rs   = bus.RS_list[0];
                    idx_d   = '0;
                    state_d = ST_FRAME;
                end
            end
            ST_FRAME: begin
                if (ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        go      = 1'b1;
                        go_data = frame_q[idx_next];
                        go_rs   = rs_list_q[idx_next];
                        idx_d   = idx_next;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_PWR_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_PWR_WAIT;
            pwr_cnt_q  <= '0;
            init_idx_q <= 2'd0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            pwr_cnt_q  <= pwr_cnt_d;
            init_idx_q <= init_idx_d;
            idx_q      <= idx_d;
        end
    end

    // Frame storage carries no control meaning, so it needs no reset
    always_ff @(posedge clk) begin
        if (latch) begin
            for (int i = 0; i < FRAME_BYTES; i++) begin
                frame_q[i] <= bus.palavra[8*i +: 8];
            end
            rs_list_q <= bus.RS_list;
        end
    end

    lcd_byte_writer #(
        .SETUP_CYCLES (SETUP_CYCLES),
        .EN_CYCLES    (EN_CYCLES),
        .HOLD_CYCLES  (HOLD_CYCLES),
        .SHORT_WAIT   (SHORT_WAIT),
        .LONG_WAIT    (LONG_WAIT)
    ) u_writer (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (go),
        .data     (go_data),
        .rs       (go_rs),
        .ready    (ready),
        .lcd_data (lcd_data),
        .lcd_rs   (lcd_rs),
        .lcd_en   (lcd_en)
    );

    assign bus.busy = (state_q != ST_IDLE);
    assign bus.done = (state_q == ST_DONE);
    assign lcd_rw   = 1'b0;

endmodule
